hazard_detection_unit: RTL and testbench
========================================

Name: hazard_detection_unit

Overview:
- Stall/flush controller for the 5-stage RISC-V pipeline. It is the counterpart to operand forwarding and covers the hazards that forwarding cannot resolve.
- Detects load-use hazards in ID and inserts STALL_CYCLES bubbles through a small FSM. Detects taken branches/jumps resolved in EXE and flushes IF/ID and ID/EXE.
- Sits beside the ID stage and drives the PC, IF_ID and ID_EXE register enables and flushes. Keeps saturating performance counters for stalls and flushes.

Parameters:
- STALL_CYCLES, 1, number of bubble cycles inserted per load-use hazard (legal range 1..7).
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- arst  in  1  asynchronous reset, active-high.
- rs1_IF_ID  in  5  rs1 field of the instruction in ID.
- rs2_IF_ID  in  5  rs2 field of the instruction in ID.
- uses_rs1_IF_ID  in  1  ID instruction reads rs1.
- uses_rs2_IF_ID  in  1  ID instruction reads rs2.
- rd_ID_EXE  in  5  destination register of the instruction in EXE.
- mem_read_ID_EXE  in  1  instruction in EXE is a load.
- branch_taken_EXE  in  1  taken branch or jump resolved in EXE this cycle.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF_ID register enable.
- id_exe_bubble  out  1  zero the ID_EXE control fields (insert a NOP).
- if_id_flush  out  1  clear IF_ID to NOP.
- id_exe_flush  out  1  clear ID_EXE to NOP.
- stall_count  out  CNT_W  bubble cycles inserted since reset, saturating.
- flush_count  out  CNT_W  flush events since reset, saturating.

Behaviour:
- Reset (arst=1, asynchronous):
  - state=RUN, bubble counter=0, stall_count=0, flush_count=0.
  - Outputs take their RUN/no-hazard values: pc_write=1, if_id_write=1, all other 1-bit outputs 0.
- Hazard detect, combinational:
  - hz = mem_read_ID_EXE && rd_ID_EXE!=0 && ((uses_rs1_IF_ID && rs1_IF_ID==rd_ID_EXE) || (uses_rs2_IF_ID && rs2_IF_ID==rd_ID_EXE)).
  - x0 never causes a hazard.
- FSM states: RUN and STALL. Outputs are combinational from the state and current inputs (Mealy), so they act in the same cycle.
- RUN:
  - If branch_taken_EXE: if_id_flush=1, id_exe_flush=1, pc_write=1, if_id_write=1; flush_count+1; stay in RUN. Branch wins over hz.
  - Else if hz: pc_write=0, if_id_write=0, id_exe_bubble=1; stall_count+1. If STALL_CYCLES==1 stay in RUN; otherwise go to STALL with bubble counter=STALL_CYCLES-1.
  - Else all pass-through values.
- STALL:
  - pc_write=0, if_id_write=0, id_exe_bubble=1; stall_count+1; bubble counter decrements.
  - When the counter reaches 1 in this cycle, the next state is RUN.
  - hz is ignored while in STALL, because EXE holds bubbles.
  - branch_taken_EXE in STALL cannot occur legally. If it is asserted anyway: apply the flush outputs, abort the stall, go to RUN, and clear the counter.
- Re-evaluation in RUN after a stall: the load has moved to MEM, so hz deasserts and forwarding supplies the operand.
- Back-to-back hazards are each stalled independently.
- Counters:
  - Both increment by 1 per qualifying cycle/event and saturate at 2^CNT_W-1 (no wrap).
  - A cycle that is both a flush and a stall counts as a flush only.
- Asserting arst mid-stall returns the FSM to RUN asynchronously, zeroes the counters, and restores the pass-through outputs immediately.

Decomposition:
- Shared package pipeline_pkg:
  - hz_state_t enum {RUN, STALL}.
  - REG_X0 = 5'd0.
  - NOP encoding, for the flush consumers.
- One natural sub-module: sat_counter (CNT_W-wide, inc, arst), instantiated twice for stall_count and flush_count.

Test Plan:
- Reset:
  - Stimulus: arst=1 with random inputs.
  - Required: pc_write=1, if_id_write=1, bubble/flush outputs=0, counts=0. Outputs stay so while arst=1.
- Load-use, STALL_CYCLES=1:
  - Stimulus: mem_read_ID_EXE=1, rd_ID_EXE=5, rs2_IF_ID=5, uses_rs2=1.
  - Required: one cycle with pc_write=0, if_id_write=0, id_exe_bubble=1. Next cycle, with mem_read=0, all pass-through. stall_count=1.
- x0 and unused operand:
  - Stimulus A: rd_ID_EXE=0, rs1=0 with a load. Stimulus B: rs1 match but uses_rs1=0.
  - Required: no stall in either case; stall_count unchanged.
- Branch priority:
  - Stimulus: hz true and branch_taken_EXE=1 in the same cycle.
  - Required: if_id_flush=id_exe_flush=1, pc_write=1, id_exe_bubble=0. flush_count=1, stall_count=0.
- STALL_CYCLES=3:
  - Stimulus: single hazard.
  - Required: exactly 3 consecutive bubble cycles, then RUN. stall_count=3.
  - Stimulus: arst pulsed in the 2nd bubble.
  - Required: immediate pass-through outputs; counters=0.
- Saturation:
  - Stimulus: CNT_W=4 with 20 stall events.
  - Required: stall_count holds at 15.

Source files
------------

// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline definitions for the hazard unit and its flush consumers.
package pipeline_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  localparam logic [4:0]  REG_X0 = 5'd0;
  // addi x0, x0, 0: what IF_ID / ID_EXE hold after a flush.
  localparam logic [31:0] NOP    = 32'h0000_0013;

  function automatic logic src_collides(input logic       uses,
                                        input logic [4:0] rs,
                                        input logic [4:0] rd);
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_detection_unit_if.sv
// ID/EXE hazard-control bundle; master is the pipeline, slave is the hazard unit.
interface hazard_detection_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       rs1_IF_ID;
  logic [4:0]       rs2_IF_ID;
  logic             uses_rs1_IF_ID;
  logic             uses_rs2_IF_ID;
  logic [4:0]       rd_ID_EXE;
  logic             mem_read_ID_EXE;
  logic             branch_taken_EXE;
  logic             pc_write;
  logic             if_id_write;
  logic             id_exe_bubble;
  logic             if_id_flush;
  logic             id_exe_flush;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output rs1_IF_ID, rs2_IF_ID, uses_rs1_IF_ID, uses_rs2_IF_ID,
           rd_ID_EXE, mem_read_ID_EXE, branch_taken_EXE,
    input  pc_write, if_id_write, id_exe_bubble, if_id_flush, id_exe_flush,
           stall_count, flush_count
  );

  modport slave (
    input  rs1_IF_ID, rs2_IF_ID, uses_rs1_IF_ID, uses_rs2_IF_ID,
           rd_ID_EXE, mem_read_ID_EXE, branch_taken_EXE,
    output pc_write, if_id_write, id_exe_bubble, if_id_flush, id_exe_flush,
           stall_count, flush_count
  );
endinterface

// File: rtl/hazard_detection_unit_sat_counter.sv
// Saturating up-counter with asynchronous active-high clear.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use stall and taken-branch flush controller with stall/flush counters.
module hazard_detection_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   arst,
  hazard_detection_unit_if.slave hdu
);
  hz_state_t  r_state;
  logic [2:0] r_bubble_cnt;

  hz_state_t  w_next_state;
  logic [2:0] w_next_cnt;
  logic       w_hz;
  logic       w_stall_inc;
  logic       w_flush_inc;
  logic       w_pc_write;
  logic       w_if_id_write;
  logic       w_bubble;
  logic       w_flush;

  assign w_hz = hdu.mem_read_ID_EXE && (hdu.rd_ID_EXE != REG_X0) &&
                (src_collides(hdu.uses_rs1_IF_ID, hdu.rs1_IF_ID, hdu.rd_ID_EXE) ||
                 src_collides(hdu.uses_rs2_IF_ID, hdu.rs2_IF_ID, hdu.rd_ID_EXE));

  // Outputs are Mealy; arst forces pass-through so reset acts without a clock.
  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_bubble_cnt;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_bubble      = 1'b0;
    w_flush       = 1'b0;
    if (!arst) begin
      unique case (r_state)
        RUN: begin
          if (hdu.branch_taken_EXE) begin
            w_flush     = 1'b1;
            w_flush_inc = 1'b1;
          end else if (w_hz) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_bubble      = 1'b1;
            w_stall_inc   = 1'b1;
            if (STALL_CYCLES > 1) begin
              w_next_state = STALL;
              w_next_cnt   = 3'(STALL_CYCLES - 1);
            end
          end
        end
        STALL: begin
          if (hdu.branch_taken_EXE) begin
            w_flush      = 1'b1;
            w_flush_inc  = 1'b1;
            w_next_state = RUN;
            w_next_cnt   = '0;
          end else begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_bubble      = 1'b1;
            w_stall_inc   = 1'b1;
            w_next_cnt    = r_bubble_cnt - 3'd1;
            if (r_bubble_cnt == 3'd1) begin
              w_next_state = RUN;
            end
          end
        end
        default: w_next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state      <= RUN;
      r_bubble_cnt <= '0;
    end else begin
      r_state      <= w_next_state;
      r_bubble_cnt <= w_next_cnt;
    end
  end

  assign hdu.pc_write      = w_pc_write;
  assign hdu.if_id_write   = w_if_id_write;
  assign hdu.id_exe_bubble = w_bubble;
  assign hdu.if_id_flush   = w_flush;
  assign hdu.id_exe_flush  = w_flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .arst    (arst),
    .i_inc   (w_stall_inc),
    .o_count (hdu.stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .arst    (arst),
    .i_inc   (w_flush_inc),
    .o_count (hdu.flush_count)
  );
endmodule

// File: tb/tb_hazard_detection_unit.sv
// Three parameterisations driven by common stimulus, checked against a bubble-budget model.
module tb_hazard_detection_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       arst;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, br;

    hazard_detection_unit_if #(.CNT_W(16)) if_a ();
    hazard_detection_unit_if #(.CNT_W(16)) if_b ();
    hazard_detection_unit_if #(.CNT_W(4))  if_c ();

    assign if_a.rs1_IF_ID = rs1; assign if_a.rs2_IF_ID = rs2; assign if_a.uses_rs1_IF_ID = u1;
    assign if_a.uses_rs2_IF_ID = u2; assign if_a.rd_ID_EXE = rd; assign if_a.mem_read_ID_EXE = mr;
    assign if_a.branch_taken_EXE = br;
    assign if_b.rs1_IF_ID = rs1; assign if_b.rs2_IF_ID = rs2; assign if_b.uses_rs1_IF_ID = u1;
    assign if_b.uses_rs2_IF_ID = u2; assign if_b.rd_ID_EXE = rd; assign if_b.mem_read_ID_EXE = mr;
    assign if_b.branch_taken_EXE = br;
    assign if_c.rs1_IF_ID = rs1; assign if_c.rs2_IF_ID = rs2; assign if_c.uses_rs1_IF_ID = u1;
    assign if_c.uses_rs2_IF_ID = u2; assign if_c.rd_ID_EXE = rd; assign if_c.mem_read_ID_EXE = mr;
    assign if_c.branch_taken_EXE = br;

    hazard_detection_unit #(.STALL_CYCLES(1), .CNT_W(16)) u_dut_a (.clk(clk), .arst(arst), .hdu(if_a.slave));
    hazard_detection_unit #(.STALL_CYCLES(3), .CNT_W(16)) u_dut_b (.clk(clk), .arst(arst), .hdu(if_b.slave));
    hazard_detection_unit #(.STALL_CYCLES(1), .CNT_W(4))  u_dut_c (.clk(clk), .arst(arst), .hdu(if_c.slave));

    logic [4:0]  obs_ctl [3];
    logic [31:0] obs_s   [3];
    logic [31:0] obs_f   [3];
    assign obs_ctl[0] = {if_a.pc_write, if_a.if_id_write, if_a.id_exe_bubble, if_a.if_id_flush, if_a.id_exe_flush};
    assign obs_ctl[1] = {if_b.pc_write, if_b.if_id_write, if_b.id_exe_bubble, if_b.if_id_flush, if_b.id_exe_flush};
    assign obs_ctl[2] = {if_c.pc_write, if_c.if_id_write, if_c.id_exe_bubble, if_c.if_id_flush, if_c.id_exe_flush};
    assign obs_s[0] = 32'(if_a.stall_count); assign obs_f[0] = 32'(if_a.flush_count);
    assign obs_s[1] = 32'(if_b.stall_count); assign obs_f[1] = 32'(if_b.flush_count);
    assign obs_s[2] = 32'(if_c.stall_count); assign obs_f[2] = 32'(if_c.flush_count);

    // {pc_write, if_id_write, id_exe_bubble, if_id_flush, id_exe_flush}
    localparam logic [4:0] C_PASS  = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00100;
    localparam logic [4:0] C_FLUSH = 5'b11011;

    int sc   [3] = '{1, 3, 1};
    int cmax [3] = '{65535, 65535, 15};
    int left [3];
    int scnt [3];
    int fcnt [3];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            left[k] = 0; scnt[k] = 0; fcnt[k] = 0;
        end
    endfunction

    function automatic bit load_use();
        return mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    endfunction

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic e1, input logic e2,
                         input logic [4:0] d, input logic ld, input logic b);
        rs1 = a1; rs2 = a2; u1 = e1; u2 = e2; rd = d; mr = ld; br = b;
    endtask

    task automatic drive_random();
        drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 9) == 0));
    endtask

    // One clock: check Mealy outputs and counters, then advance the model across the edge.
    task automatic cycle();
        logic [4:0] exp_ctl;
        int nl [3];
        int si [3];
        int fi [3];
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_ctl = C_PASS; nl[k] = left[k]; si[k] = 0; fi[k] = 0;
            if (left[k] > 0) begin
                if (br) begin exp_ctl = C_FLUSH; fi[k] = 1; nl[k] = 0; end
                else begin exp_ctl = C_STALL; si[k] = 1; nl[k] = left[k] - 1; end
            end else if (br) begin
                exp_ctl = C_FLUSH; fi[k] = 1;
            end else if (load_use()) begin
                exp_ctl = C_STALL; si[k] = 1; nl[k] = sc[k] - 1;
            end
            check_eq($sformatf("ctl%0d", k), 32'(obs_ctl[k]), 32'(exp_ctl));
            check_eq($sformatf("stall_cnt%0d", k), obs_s[k], 32'(scnt[k]));
            check_eq($sformatf("flush_cnt%0d", k), obs_f[k], 32'(fcnt[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            left[k] = nl[k];
            scnt[k] = (scnt[k] + si[k] > cmax[k]) ? cmax[k] : scnt[k] + si[k];
            fcnt[k] = (fcnt[k] + fi[k] > cmax[k]) ? cmax[k] : fcnt[k] + fi[k];
        end
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("%s_ctl%0d", tag, k), 32'(obs_ctl[k]), 32'(C_PASS));
            check_eq($sformatf("%s_s%0d", tag, k), obs_s[k], 32'd0);
            check_eq($sformatf("%s_f%0d", tag, k), obs_f[k], 32'd0);
        end
    endtask

    task automatic pulse_reset();
        #1 arst = 1'b1;
        #1 check_reset_state("arst_pulse");
        model_reset();
        arst = 1'b0;
    endtask

    initial begin
        arst = 1'b1;
        drive_random();
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive_random();
            #1 check_reset_state("reset");
            @(negedge clk);
        end
        arst = 1'b0;

        // Load-use through rs2, then idle while the 3-cycle instance drains.
        drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0); cycle();
        for (int i = 0; i < 3; i++) begin drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0); cycle(); end
        check_eq("ls_cnt_sc1", obs_s[0], 32'd1);
        check_eq("ls_cnt_sc3", obs_s[1], 32'd3);

        // x0 destination and unused matching operand never stall.
        drive(5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0); cycle();
        drive(5'd5, 5'd3, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0); cycle();
        check_eq("x0_unused_cnt", obs_s[0], 32'd1);

        // Branch beats a simultaneous load-use.
        drive(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1); cycle();
        check_eq("br_prio_flush", obs_f[0], 32'd1);
        check_eq("br_prio_stall", obs_s[0], 32'd1);

        // Reset asserted during the second bubble of the 3-cycle instance.
        drive(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0); cycle();
        drive(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0);
        check_eq("mid_stall_pre", 32'(obs_ctl[1]), 32'(C_STALL));
        pulse_reset();
        cycle();

        // Saturation of the 4-bit instance.
        for (int i = 0; i < 20; i++) begin
            drive(5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0); cycle();
            drive(5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0); cycle();
        end
        check_eq("sat_hold", obs_s[2], 32'd15);

        for (int i = 0; i < 600; i++) begin
            drive_random();
            if ($urandom_range(0, 49) == 0) pulse_reset();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
